// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_segment_scan #(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_COUNT = 50000,
    parameter int CNT_BITS      = 16,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [3:0]            hex_digit,
    input  logic [6:0]            seg_from_rom,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic                  frame_done
);

    localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(REFRESH_COUNT - 1);
    localparam logic [CNT_BITS-1:0] CNT_GUARD = CNT_BITS'(GUARD_CYCLES);
    localparam logic [IDXW-1:0]     IDX_LAST  = IDXW'(N_DIGITS - 1);

    logic [CNT_BITS-1:0]   cnt;
    logic [IDXW-1:0]       idx;
    logic [4*N_DIGITS-1:0] disp_reg;
    logic [4*N_DIGITS-1:0] pend_reg;
    logic [N_DIGITS-1:0]   disp_dp;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pending;

    logic                  tick;
    logic                  frame;
    logic                  dark;
    logic                  blank_cur;
    logic                  dp_cur;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   onehot;

    assign tick      = enable & (cnt == CNT_LAST);
    assign frame     = tick & (idx == IDX_LAST);
    assign hex_digit = disp_reg[4*idx +: 4];
    assign onehot    = N_DIGITS'(1) << idx;
    assign dark      = ~enable | (cnt < CNT_GUARD);
    assign dp_cur    = disp_dp[idx];
    assign blank_cur = blank[idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic hi_nz;

    // A digit is blank while it and everything above it are zero.
    always_comb begin
        blank = '0;
        hi_nz = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            hi_nz    = hi_nz | (disp_reg[4*k +: 4] != 4'h0);
            blank[k] = ~hi_nz;
        end
    end
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            disp_dp    <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg_out    <= 7'h7F;
            dp_out     <= 1'b1;
            anode_n    <= '1;
        end else begin
            if (enable)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame_done <= frame;

            // Swap only at a frame start so a frame never mixes two values.
            if (frame & pending) begin
                disp_reg <= pend_reg;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_reg <= value_in;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (frame) begin
                pending  <= 1'b0;
            end

            if (dark) begin
                anode_n <= '1;
                seg_out <= 7'h7F;
                dp_out  <= 1'b1;
            end else if (blank_cur) begin
                anode_n <= dp_cur ? ~onehot : '1;
                seg_out <= 7'h7F;
                dp_out  <= ~dp_cur;
            end else begin
                anode_n <= ~onehot;
                seg_out <= seg_from_rom;
                dp_out  <= ~dp_cur;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized bench for seven_segment_scan against a scan-position reference model.
// Build with LEADING_ZERO_BLANK_EN defined to check the blanking variant.
module tb_seven_segment_scan;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int G  = 1;
    localparam int CB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         load;
    logic [15:0]  value_in;
    logic [3:0]   dp_in;
    logic [3:0]   hex_digit;
    logic [6:0]   seg_from_rom;
    logic [6:0]   seg_out;
    logic         dp_out;
    logic [3:0]   anode_n;
    logic         frame_done;

    int checks   = 0;
    int failures = 0;

    // Model state: total enabled cycles since reset fixes cnt and idx.
    int           steps;
    logic [15:0]  m_disp;
    logic [15:0]  m_pend;
    logic [3:0]   m_ddp;
    logic [3:0]   m_pdp;
    bit           m_pending;
    logic [3:0]   e_an;
    logic [6:0]   e_seg;
    logic         e_dp;
    logic         e_fd;

    seven_segment_scan #(
        .N_DIGITS(N), .REFRESH_COUNT(R), .CNT_BITS(CB), .GUARD_CYCLES(G)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value_in(value_in), .dp_in(dp_in), .hex_digit(hex_digit),
        .seg_from_rom(seg_from_rom), .seg_out(seg_out), .dp_out(dp_out),
        .anode_n(anode_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rom(input logic [3:0] d);
        case (d)
            4'h0: rom = 7'h40;  4'h1: rom = 7'h79;
            4'h2: rom = 7'h24;  4'h3: rom = 7'h30;
            4'h4: rom = 7'h19;  4'h5: rom = 7'h12;
            4'h6: rom = 7'h02;  4'h7: rom = 7'h78;
            4'h8: rom = 7'h00;  4'h9: rom = 7'h10;
            4'hA: rom = 7'h08;  4'hB: rom = 7'h03;
            4'hC: rom = 7'h46;  4'hD: rom = 7'h21;
            4'hE: rom = 7'h06;  default: rom = 7'h0E;
        endcase
    endfunction

    assign seg_from_rom = rom(hex_digit);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        int         c;
        int         i;
        bit         blank;
        logic [3:0] oh;
        logic [3:0] nib;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            steps = 0; m_disp = '0; m_pend = '0;
            m_ddp = '0; m_pdp = '0; m_pending = 0;
        end else begin
            c     = steps % R;
            i     = (steps / R) % N;
            oh    = 4'b0001 << i;
            nib   = 4'(m_disp >> (4 * i));
            blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (i > 0) && ((m_disp >> (4 * i)) == 0);
`endif
            if (!enable || c < G) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else if (blank) begin
                e_seg = 7'h7F;
                e_dp  = ~m_ddp[i];
                e_an  = m_ddp[i] ? ~oh : 4'hF;
            end else begin
                e_an  = ~oh;
                e_seg = rom(nib);
                e_dp  = ~m_ddp[i];
            end
            e_fd = enable && (steps % (R * N) == R * N - 1);
            if (e_fd && m_pending) begin
                m_disp = m_pend; m_ddp = m_pdp; m_pending = 0;
            end
            if (load) begin
                m_pend = value_in; m_pdp = dp_in; m_pending = 1;
            end
            if (enable) steps++;
        end
        @(posedge clk);
        #1;
        chk("anode_n", anode_n, e_an);
        chk("seg_out", seg_out, e_seg);
        chk("dp_out", dp_out, e_dp);
        chk("frame_done", frame_done, e_fd);
        chk("hex_digit", hex_digit, 4'(m_disp >> (4 * ((steps / R) % N))));
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < R * N && (steps % (R * N)) != pos; k++)
            cycle();
        chk("align", steps % (R * N), pos);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b1;
        value_in = 16'hBEEF; dp_in = 4'hF;
        repeat (3) cycle();
        reset = 1'b0; load = 1'b0; dp_in = 4'h0;
        repeat (20) cycle();

        load = 1'b1; value_in = 16'h1234;
        cycle();
        load = 1'b0;
        repeat (40) cycle();

        run_to(5);
        load = 1'b1; value_in = 16'h5555;
        cycle();
        load = 1'b0;
        run_to(15);
        load = 1'b1; value_in = 16'hAAAA;
        cycle();
        load = 1'b0;
        repeat (48) cycle();

        load = 1'b1; value_in = 16'h0000; dp_in = 4'b0100;
        cycle();
        load = 1'b0; dp_in = 4'h0;
        repeat (40) cycle();

        load = 1'b1; value_in = 16'h0070;
        cycle();
        load = 1'b0;
        repeat (40) cycle();

        run_to(9);
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        repeat (40) cycle();

        repeat (1500) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 7) == 0);
            value_in = ($urandom_range(0, 2) == 0) ?
                       16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in  = 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
